scl_hdown_n: RTL and testbench



---
 rtl/scl_hdown_n.sv | 159 +++++++++++++++
 tb/tb_scl_hdown_n.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/scl_hdown_n.sv
// Horizontal downscaler: bypass, or /2, /4, /8 per line with four filters.
// Optional status counters are built in when SCL_HDOWN_STATUS_EN is defined.
module scl_hdown_n #(
  parameter int DW  = 8,
  parameter int CH  = 3,
  parameter int PCW = 16
) (
  input  logic             clk_scl,
  input  logic             rst_scl,
  input  logic             scl_i_vsync,
  input  logic             scl_i_hsync,
  input  logic             scl_i_data_en,
  input  logic [CH*DW-1:0] scl_i_data,
  input  logic             scl_cfg_mode,
  input  logic [1:0]       scl_cfg_rsz,
  input  logic [1:0]       scl_cfg_flt,
  output logic             scl_o_vsync,
  output logic             scl_o_hsync,
  output logic             scl_o_data_en,
  output logic [CH*DW-1:0] scl_o_data
`ifdef SCL_HDOWN_STATUS_EN
  ,
  output logic [PCW-1:0]   scl_o_pcnt,
  output logic [0:0]       scl_o_partial
`endif
);

  localparam int AW = DW + 3;
  localparam int SW = DW + 4;

  logic             en_q, armed_q, armed_d;
  logic             mode_q, mode_d;
  logic [1:0]       rsz_q, rsz_d;
  logic [1:0]       flt_q, flt_d;
  logic [2:0]       ph_q, ph_d;
  logic [CH-1:0][AW-1:0] acc_q, acc_d;
  logic [CH-1:0][DW-1:0] fst_q, fst_d;
  logic             vs_q, hs_q;
  logic             oen_q, oen_d;
  logic [CH*DW-1:0] odat_q, odat_d;

  logic             ls, vld, fall, byp, scl, last;
  logic [1:0]       k;
  logic [2:0]       ph, lastp;
  logic [SW-1:0]    half;
  logic [CH*DW-1:0] res;

  always_comb begin
    ls     = scl_i_data_en & ~en_q;
    fall   = en_q & ~scl_i_data_en;
    vld    = scl_i_data_en & armed_q;
    mode_d = ls ? scl_cfg_mode : mode_q;
    rsz_d  = ls ? scl_cfg_rsz  : rsz_q;
    flt_d  = ls ? scl_cfg_flt  : flt_q;
    k      = 2'd3;
    lastp  = 3'd7;
    half   = SW'(4);
    case (rsz_d)
      2'd0: begin k = 2'd1; lastp = 3'd1; half = SW'(1); end
      2'd1: begin k = 2'd2; lastp = 3'd3; half = SW'(2); end
      default: ;
    endcase
    ph   = ls ? 3'd0 : ph_q;
    byp  = vld & ~mode_d;
    scl  = vld & mode_d;
    last = scl & (ph == lastp);
    res  = '0;
    acc_d = acc_q;
    fst_d = fst_q;
    for (int c = 0; c < CH; c++) begin
      logic [DW-1:0] pix;
      logic [AW-1:0] sum;
      logic [SW-1:0] rnd;
      pix = scl_i_data[c*DW +: DW];
      sum = (ph == 3'd0) ? AW'(pix) : acc_q[c] + AW'(pix);
      rnd = (SW'(sum) + half) >> k;
      case (flt_d)
        2'd0: res[c*DW +: DW] = fst_q[c];
        2'd1: res[c*DW +: DW] = pix;
        2'd2: res[c*DW +: DW] = DW'(sum >> k);
        default:
          res[c*DW +: DW] = (rnd > SW'({DW{1'b1}})) ?
                            {DW{1'b1}} : DW'(rnd);
      endcase
      if (scl) acc_d[c] = sum;
      if (scl && ph == 3'd0) fst_d[c] = pix;
    end
    if (scl) ph_d = last ? 3'd0 : ph + 3'd1;
    else     ph_d = ph;
    armed_d = armed_q | ~scl_i_data_en;
    oen_d   = byp | last;
    odat_d  = byp ? scl_i_data : (last ? res : odat_q);
  end

  always_ff @(posedge clk_scl) begin
    if (rst_scl) begin
      en_q    <= 1'b0;
      armed_q <= 1'b0;
      mode_q  <= 1'b0;
      rsz_q   <= 2'd0;
      flt_q   <= 2'd0;
      ph_q    <= 3'd0;
      acc_q   <= '0;
      fst_q   <= '0;
      vs_q    <= 1'b1;
      hs_q    <= 1'b1;
      oen_q   <= 1'b0;
      odat_q  <= '0;
    end else begin
      en_q    <= scl_i_data_en;
      armed_q <= armed_d;
      mode_q  <= mode_d;
      rsz_q   <= rsz_d;
      flt_q   <= flt_d;
      ph_q    <= ph_d;
      acc_q   <= acc_d;
      fst_q   <= fst_d;
      vs_q    <= scl_i_vsync;
      hs_q    <= scl_i_hsync;
      oen_q   <= oen_d;
      odat_q  <= odat_d;
    end
  end

  assign scl_o_vsync   = vs_q;
  assign scl_o_hsync   = hs_q;
  assign scl_o_data_en = oen_q;
  assign scl_o_data    = odat_q;

`ifdef SCL_HDOWN_STATUS_EN
  logic [PCW-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d;
  logic           part_q, part_d;

  always_comb begin
    cnt_d = ls ? '0 : cnt_q;
    if ((byp | last) && cnt_d != {PCW{1'b1}}) cnt_d = cnt_d + 1'b1;
    pcnt_d = (fall & armed_q) ? cnt_q : pcnt_q;
    // a group left open when the line ends is a discarded partial
    part_d = part_q |
             (fall & armed_q & mode_q & (ph_q != 3'd0));
  end

  always_ff @(posedge clk_scl) begin
    if (rst_scl) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      part_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      part_q <= part_d;
    end
  end

  assign scl_o_pcnt    = pcnt_q;
  assign scl_o_partial = part_q;
`endif

endmodule

// File: tb/tb_scl_hdown_n.sv
// Scoreboard bench for scl_hdown_n: directed lines, queued expectations.
// Status ports are checked when SCL_HDOWN_STATUS_EN is defined.
module tb_scl_hdown_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs, hs, en;
  logic [23:0] din;
  logic        cmode;
  logic [1:0]  crsz, cflt;
  logic        o_vs, o_hs, o_en;
  logic [23:0] o_dat;
`ifdef SCL_HDOWN_STATUS_EN
  logic [15:0] pcnt;
  logic [0:0]  partial;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];
  logic [23:0] px[16];

  always #5 clk = ~clk;

  scl_hdown_n dut (
    .clk_scl(clk),
    .rst_scl(rst),
    .scl_i_vsync(vs),
    .scl_i_hsync(hs),
    .scl_i_data_en(en),
    .scl_i_data(din),
    .scl_cfg_mode(cmode),
    .scl_cfg_rsz(crsz),
    .scl_cfg_flt(cflt),
    .scl_o_vsync(o_vs),
    .scl_o_hsync(o_hs),
    .scl_o_data_en(o_en),
    .scl_o_data(o_dat)
`ifdef SCL_HDOWN_STATUS_EN
    ,
    .scl_o_pcnt(pcnt),
    .scl_o_partial(partial)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic cyc(input logic e, input logic [23:0] d);
    @(negedge clk);
    en  = e;
    din = d;
    hs  = ~e;
    vs  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 24'h0);
  endtask

  // chg_at < 0 disables the mid-line filter change
  task automatic line(input logic m, input logic [1:0] r,
                      input logic [1:0] f, input int n,
                      input int chg_at, input logic [1:0] chg_f);
    cmode = m;
    crsz  = r;
    cflt  = f;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, px[i]);
      if (i == chg_at) cflt = chg_f;
    end
    idle(3);
  endtask

  initial begin
    logic evs, ehs, erst;
    forever begin
      @(posedge clk);
      erst = rst;
      evs  = erst ? 1'b1 : vs;
      ehs  = erst ? 1'b1 : hs;
      @(negedge clk);
      check("vsync_dly", 32'(o_vs), 32'(evs));
      check("hsync_dly", 32'(o_hs), 32'(ehs));
      if (o_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(o_dat), 32'hFFFF_FFFF);
        end else begin
          check("out_pixel", 32'(o_dat), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; din = '0; vs = 1'b0; hs = 1'b1;
    cmode = 1'b0; crsz = 2'd0; cflt = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_en",   32'(o_en),  32'd0);
    check("rst_data", 32'(o_dat), 32'd0);
    check("rst_vs",   32'(o_vs),  32'd1);
    check("rst_hs",   32'(o_hs),  32'd1);
`ifdef SCL_HDOWN_STATUS_EN
    check("rst_pcnt", 32'(pcnt),    32'd0);
    check("rst_part", 32'(partial), 32'd0);
`endif
    rst = 1'b0;
    idle(3);

    px[0] = 24'h010203; px[1] = 24'h020304; px[2] = 24'h030405;
    px[3] = 24'h040506; px[4] = 24'h050607; px[5] = 24'h060708;
    px[6] = 24'h070808; px[7] = 24'h080808;
    for (int i = 0; i < 8; i++) exp_q.push_back(px[i]);
    line(1'b0, 2'd0, 2'd0, 8, -1, 2'd0);

    px[0] = 24'hFF000A; px[1] = 24'hFF010D;
    px[2] = 24'hFF02C8; px[3] = 24'hFF03FF;
    exp_q.push_back(24'hFF010C); exp_q.push_back(24'hFF03E4);
    line(1'b1, 2'd0, 2'd3, 4, -1, 2'd0);
    exp_q.push_back(24'hFF000B); exp_q.push_back(24'hFF02E3);
    line(1'b1, 2'd0, 2'd2, 4, -1, 2'd0);

    for (int i = 0; i < 8; i++) px[i] = {3{8'(i + 1)}};
    exp_q.push_back(24'h010101); exp_q.push_back(24'h050505);
    line(1'b1, 2'd1, 2'd0, 8, 2, 2'd1);
    exp_q.push_back(24'h040404); exp_q.push_back(24'h080808);
    line(1'b1, 2'd1, 2'd1, 8, -1, 2'd0);

    for (int i = 0; i < 12; i++) px[i] = 24'hFFFFFF;
    exp_q.push_back(24'hFFFFFF);
    line(1'b1, 2'd2, 2'd3, 12, -1, 2'd0);
`ifdef SCL_HDOWN_STATUS_EN
    check("pcnt_div8", 32'(pcnt),    32'd1);
    check("part_div8", 32'(partial), 32'd1);
`endif

    for (int i = 0; i < 16; i++) px[i] = {3{8'(i)}};
    exp_q.push_back(24'h030303); exp_q.push_back(24'h0B0B0B);
    line(1'b1, 2'd3, 2'd2, 16, -1, 2'd0);

    cmode = 1'b1; crsz = 2'd0; cflt = 2'd0;
    cyc(1'b1, 24'h010101);
    cyc(1'b1, 24'h020202);
    rst = 1'b1;
    cyc(1'b1, 24'h030303);
    rst = 1'b0;
    cyc(1'b1, 24'h040404);
    idle(3);
    for (int i = 0; i < 4; i++) px[i] = {3{8'(i + 1)}};
    exp_q.push_back(24'h010101); exp_q.push_back(24'h030303);
    line(1'b1, 2'd0, 2'd0, 4, -1, 2'd0);
`ifdef SCL_HDOWN_STATUS_EN
    check("pcnt_rst", 32'(pcnt),    32'd2);
    check("part_rst", 32'(partial), 32'd0);
`endif

    idle(5);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
